// File: rtl/seq_restoring_divider_pkg.sv
// Purpose : shared constants and FSM encoding for the sequential restoring divider.
// Latency : n/a (package only).
// Backpressure: n/a; exports div_state_t, DIV_WIDTH, DIV_CNT_W, QUOT_ALL_ONES.
package seq_restoring_divider_pkg;

  // Default operand width and the matching step-counter width.
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported on divide-by-zero. Kept wider than the default so any
  // width up to 64 can slice it down.
  localparam int                   DIV_MAX_W     = 64;
  localparam logic [DIV_MAX_W-1:0] QUOT_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// Purpose : combinational W-bit a - b, as a ripple of 4-bit carry-lookahead blocks
//           plus one top bit; ports a, b in; diff, borrow (= ~carry_out) out.
// Latency : purely combinational. Backpressure: none.
module cla_subtractor #(
  parameter int W = 33  // must be 4*k + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int NB = (W - 1) / 4;  // number of 4-bit lookahead blocks

  logic [W-1:0] b_n;
  logic [NB:0]  c;      // carry into each block; c[0] is the +1 of two's complement
  logic         g_top;
  logic         p_top;

  assign b_n  = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    assign g     = a[4*i +: 4] & b_n[4*i +: 4];
    assign p     = a[4*i +: 4] ^ b_n[4*i +: 4];
    assign cc[0] = c[i];
    assign cc[1] = g[0] | (p[0] & cc[0]);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cc[0]);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cc[0]);

    assign diff[4*i +: 4] = p ^ cc[3:0];
    assign c[i+1]         = cc[4];
  end

  // Odd top bit that makes the subtract one wider than the operands.
  assign g_top     = a[W-1] & b_n[W-1];
  assign p_top     = a[W-1] ^ b_n[W-1];
  assign diff[W-1] = p_top ^ c[NB];
  assign borrow    = ~(g_top | (p_top & c[NB]));

endmodule

// File: rtl/seq_restoring_divider.sv
// Purpose : multi-cycle unsigned restoring divider, one quotient bit per cycle.
//           Ports: clk, reset, start, dividend, divisor in; busy, done, quotient,
//           remainder, div_by_zero out.
// Latency : done WIDTH+1 cycles after an accepted start (1 cycle for divisor 0).
// Backpressure: start is only sampled in IDLE; starts during RUN/FINISH are dropped.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // multiple of 4, at most DIV_MAX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q;      // partial remainder R
  logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] divisor_q;

  logic [WIDTH:0]   t_ext;
  logic [WIDTH:0]   d_ext;
  logic             sub_borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;
  logic             unused_d_msb;

  // R < divisor always holds, so the bit shifted out of R is kept as the
  // extra MSB of the trial subtract instead of being dropped.
  assign t_ext = {rem_q, quo_q[WIDTH-1]};

  cla_subtractor #(.W(WIDTH + 1)) u_sub (
    .a      (t_ext),
    .b      ({1'b0, divisor_q}),
    .diff   (d_ext),
    .borrow (sub_borrow)
  );

  // Without a borrow the difference fits in WIDTH bits, so its MSB is always 0.
  assign unused_d_msb = d_ext[WIDTH];
  assign next_rem     = sub_borrow ? t_ext[WIDTH-1:0] : d_ext[WIDTH-1:0];
  assign next_quo     = {quo_q[WIDTH-2:0], ~sub_borrow};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            divisor_q   <= divisor;
            rem_q       <= '0;
            quo_q       <= dividend;
            count       <= CNT_W'(WIDTH - 1);
            div_by_zero <= 1'b0;
            if (divisor != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              // Skip RUN entirely; result is fixed by convention.
              state       <= ST_FINISH;
              done        <= 1'b1;
              quotient    <= WIDTH'(QUOT_ALL_ONES);
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          rem_q <= next_rem;
          quo_q <= next_quo;
          if (count == '0) begin
            // Last step: publish the result so it is valid alongside done.
            state     <= ST_FINISH;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= next_quo;
            remainder <= next_rem;
          end else begin
            count <= count - 1'b1;
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Purpose : scoreboard bench for seq_restoring_divider (directed + random operands).
// Latency : checks done latency and busy length per division.
// Backpressure: issues starts only while the DUT is idle, except deliberate ignored ones.
module tb_seq_restoring_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  seq_restoring_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result for every done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
    prev_done = (done === 1'b1);
  end

  // Issue one division and wait for its done; optionally pulse an ignored
  // start (9/3) after intrude_at cycles of RUN.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int intrude_at);
    exp_t e;
    int   lat;
    int   bc;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    exp_q.push_back(e);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 1;
    bc  = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bc++;
      if (lat == intrude_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, (b == 0) ? 32'd1 : 32'd33);
    check("busy_cycles", bc, (b == 0) ? 32'd0 : 32'd32);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    // Directed vectors with hand-computed results.
    run_div(32'd100, 32'd7, -1);                 // 14 r 2
    run_div(32'hFFFF_FFFF, 32'd1, -1);           // all ones r 0
    run_div(32'd5, 32'd0, -1);                   // divide by zero
    run_div(32'd3, 32'd10, -1);                  // 0 r 3
    run_div(32'h8000_0000, 32'h8000_0001, -1);   // 0 r 0x80000000
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);   // 1 r 0
    run_div(32'd100, 32'd7, 10);                 // start mid-run ignored
    run_div(32'd9, 32'd3, -1);                   // 3 r 0

    // Reset in the middle of RUN: no done, outputs cleared.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (40) @(negedge clk);
    run_div(32'd50, 32'd5, -1);                  // 10 r 0

    // Random operand pairs, mixing full-range, small and zero divisors.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case (i % 5)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = a >> $urandom_range(0, 31);
        3:       b = (i % 25 == 3) ? 32'd0 : $urandom_range(1, 65535);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(a, b, -1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
